// File: rtl/stack_data_pkg.sv
// Shared definitions for the data/operator stack: word widths and command encodings.
package stack_data_pkg;

    // Native data word width of the CPU and its all-zero constant
    localparam int CD_N = 16;
    localparam logic [CD_N-1:0] CD_0 = '0;

    // Stack command bus width
    localparam int SC_N = 2;

    // Stack commands issued by the data-stack command stage
    typedef enum logic [SC_N-1:0] {
        SC_NON = 2'd0,
        SC_PUS = 2'd1,
        SC_POP = 2'd2,
        SC_CLR = 2'd3
    } stack_cmd_e;

    // Map a raw command bus value onto a command; anything unknown is treated as idle
    function automatic stack_cmd_e decodeCmd(input logic [SC_N-1:0] raw);
        stack_cmd_e result;
        case (raw)
            2'd1:    result = SC_PUS;
            2'd2:    result = SC_POP;
            2'd3:    result = SC_CLR;
            default: result = SC_NON;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/stack_data_ram.sv
// Storage array for the stack: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the stack never exposes an unwritten slot.
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the pushed word into its slot on the rising edge
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_data.sv
// LIFO operand stack with a registered top-of-stack and empty/full/count/sticky-error status.
// The operator stack reuses this block with a narrower WIDTH.
module stack_data
    import stack_data_pkg::*;
#(
    parameter int WIDTH = CD_N,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [SC_N-1:0]  i_cmd,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count,
    output logic             o_err
);

    // One extra pointer bit so that a full stack is distinguishable from an empty one
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

    logic [AW:0]      r_sp;
    logic [WIDTH-1:0] r_top;
    logic             r_err;

    logic [AW:0]      w_spNext;
    logic [WIDTH-1:0] w_topNext;
    logic             w_errNext;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_empty;
    logic             w_full;
    stack_cmd_e       w_cmd;

    assign w_cmd   = decodeCmd(i_cmd);
    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == SP_FULL);

    // The next free slot is the write address; the entry below the current top is the read address
    // (only consulted when at least two entries are held, so the subtraction never wraps in use)
    assign w_waddr = r_sp[AW-1:0];
    assign w_raddr = r_sp[AW-1:0] - AW'(2);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Decode the command into next pointer, next top, next error flag and the RAM write enable
    always_comb begin
        w_spNext  = r_sp;
        w_topNext = r_top;
        w_errNext = r_err;
        w_we      = 1'b0;
        case (w_cmd)
            SC_PUS: begin
                if (w_full) begin
                    w_errNext = 1'b1;
                end else begin
                    w_we      = 1'b1;
                    w_spNext  = r_sp + SP_ONE;
                    w_topNext = i_data;
                end
            end
            SC_POP: begin
                if (w_empty) begin
                    w_errNext = 1'b1;
                end else if (r_sp == SP_ONE) begin
                    w_spNext  = '0;
                    w_topNext = '0;
                end else begin
                    w_spNext  = r_sp - SP_ONE;
                    w_topNext = w_rdata;
                end
            end
            SC_CLR: begin
                w_spNext  = '0;
                w_topNext = '0;
                w_errNext = 1'b0;
            end
            default: begin
                w_spNext  = r_sp;
            end
        endcase
    end

    // Stack pointer, top-of-stack and sticky error registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp  <= '0;
            r_top <= '0;
            r_err <= 1'b0;
        end else begin
            r_sp  <= w_spNext;
            r_top <= w_topNext;
            r_err <= w_errNext;
        end
    end

    assign o_top   = r_top;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_sp;
    assign o_err   = r_err;

endmodule

// File: doc/stack_data.md
Name: stack_data

Overview:
- Data-operand stack sitting directly downstream of the data-stack command stage; consumes dt_cmd and dt_data each cycle.
- Holds `CD_N-bit numbers in a LIFO and exposes a registered top-of-stack plus empty/full/count/error status.
- Status feeds back to the controller (dt_empty) and the ALU operand path.
- One instance per stack; the operator stack reuses it with WIDTH=`CO_N.

Parameters:
WIDTH, `CD_N, data word width
DEPTH, 16, number of entries; power of two, >=2
AW, 4, pointer width = log2(DEPTH)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
cmd  input  `SC_N  stack command: `SC_NON / `SC_PUS / `SC_POP / `SC_CLR
data  input  WIDTH  push data; valid only when cmd==`SC_PUS (bus is z otherwise, must not be used)
top  output  WIDTH  current top-of-stack (registered); `CD_0 when empty
empty  output  1  stack holds 0 entries
full  output  1  stack holds DEPTH entries
count  output  AW+1  number of entries, 0..DEPTH
err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (Reset=0, asynchronous, any time incl. mid-operation): sp=0, top=0, err=0; empty=1, full=0, count=0. Array contents are not reset and are never observable while empty.
- All state changes on rising Clock; one command per cycle; status valid the cycle after the command.
- State: sp (AW+1 bits) = count; top_Q register; err_Q register; storage array mem[0..DEPTH-1].
- empty = (sp==0); full = (sp==DEPTH); count = sp; all combinational from registers.
- `SC_NON: no change.
- `SC_PUS, not full: mem[sp[AW-1:0]] <= data; sp <= sp+1; top_Q <= data. top reflects pushed value 1 cycle later.
- `SC_PUS, full: no write, sp/top unchanged, err <= 1 (overflow).
- `SC_POP, sp>=2: sp <= sp-1; top_Q <= mem[sp-2]. Popped value is the old top (available to consumers in the pop cycle).
- `SC_POP, sp==1: sp <= 0; top_Q <= `CD_0.
- `SC_POP, empty: no change except err <= 1 (underflow).
- `SC_CLR: sp <= 0; top_Q <= `CD_0; err <= 0. Clear wins over any error in the same cycle.
- Undefined cmd encodings behave as `SC_NON.
- err is sticky; only Reset or `SC_CLR clears it.
- No bypass from data to top within the same cycle; top is always a register output.
- Wrap-around: pointer arithmetic never wraps; the full/empty guards prevent it. sp width AW+1 lets full be distinguished from empty.
- Back-to-back push/pop at any rate is legal. Push then pop returns the stack to the prior state and top value.

Decomposition:
- STACK_INTERFACE.v holds `SC_N, `SC_NON, `SC_PUS, `SC_POP, `SC_CLR.
- CPU_INTERNAL.v holds `CD_N and `CD_0; no new package.
- Storage array goes in sub-module stack_ram:
  - WIDTH/DEPTH parameters.
  - Synchronous write port: we, waddr, wdata.
  - One asynchronous read port: raddr, rdata.
- stack_data owns sp, top_Q, err_Q and the command decode.

Test Plan:
- Reset then idle: Reset=0 mid-cycle -> top=0, empty=1, count=0, err=0 immediately, without waiting for a clock edge.
- Push 5, 9, 12 -> top 5,9,12 on successive cycles, count=3. Then pop x3 -> top 9,5,0, empty=1 after third pop.
- Fill DEPTH=16 with values 1..16 -> full=1, top=16. 17th push of 99 -> top stays 16, count=16, err=1.
- Pop on empty -> err=1, count=0, top=0. Following push 7 -> top=7, err remains 1.
- Push 3, push 4, `SC_CLR -> count=0, top=0, err=0. Next push 8 -> top=8, count=1.
- Interleave push 1, pop, push 2, push 3, pop -> final top=2, count=1. Assert Reset low during the last pop -> all outputs at reset values.
